// File: rtl/dds_voice_scheduler.sv
// dds_voice_scheduler
//
// Polyphonic DDS sequencer. On each sample tick it walks the voice slots in
// order. Each active slot fetches its step from the note-step ROM, advances its
// phase accumulator, and reads the sine ROM. The sine samples are summed into
// one mix sample. This block also allocates voices for note-on/note-off events.
//
// Ports
//   i_clk, i_rst_n     clock; asynchronous active-low reset
//   i_sample_tick      one-cycle pulse that starts a sample computation
//   i_note_valid/o_note_ready, i_note_on, i_note_num
//                      note event handshake (see below)
//   o_note_drop        one-cycle pulse: accepted note-on found no free slot
//   o_note_addr        note-step ROM address;  i_note_step  ROM data
//   o_phase_out        sine ROM address;       i_sine_value ROM data (signed)
//   o_mix_out          signed mixed sample;    o_mix_valid  one-cycle update pulse
//   o_active_mask      bit v set = slot v holds a note
//   o_overrun          sticky: tick arrived while a sample was in progress
//   o_dbg_state        current sequencer state
//
// Handshake: an event transfers on any rising edge where
// i_note_valid && o_note_ready. o_note_ready is high only in IDLE. The source
// holds i_note_on/i_note_num stable while i_note_valid is high.
//
// Build option: define DDS_SCHED_SAT_EN to clamp the accumulator into the output
// range, so a lone voice keeps full amplitude. Without it, the accumulator is
// arithmetically shifted right by log2(VOICES), and no clipping can occur.
//
// Both ROMs have a read latency of LUT_LAT cycles, counted from the cycle the
// registered address is presented. The data is therefore consumed directly in
// the state that follows the wait.

module dds_voice_scheduler #(
    parameter int VOICES     = 4,
    parameter int DATA_WDTH  = 24,
    parameter int PHASE_WDTH = 16,
    parameter int NOTE_WDTH  = 7,
    parameter int LUT_LAT    = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_sample_tick,
    input  logic                        i_note_valid,
    output logic                        o_note_ready,
    input  logic                        i_note_on,
    input  logic [NOTE_WDTH-1:0]        i_note_num,
    output logic                        o_note_drop,
    output logic [NOTE_WDTH-1:0]        o_note_addr,
    input  logic [PHASE_WDTH-1:0]       i_note_step,
    output logic [PHASE_WDTH-1:0]       o_phase_out,
    input  logic signed [DATA_WDTH-1:0] i_sine_value,
    output logic signed [DATA_WDTH-1:0] o_mix_out,
    output logic                        o_mix_valid,
    output logic [VOICES-1:0]           o_active_mask,
    output logic                        o_overrun,
    output logic [2:0]                  o_dbg_state
);

    localparam int VW    = $clog2(VOICES);
    localparam int ACC_W = DATA_WDTH + VW;
    localparam logic [1:0] LAT_M1 = 2'(LUT_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_NOTE, S_WSTEP, S_PHASE, S_WSINE, S_ACC, S_DONE
    } state_t;

    state_t                   r_state, w_next;
    logic [VOICES-1:0]        r_active;
    logic [NOTE_WDTH-1:0]     r_note  [VOICES];
    logic [PHASE_WDTH-1:0]    r_phase [VOICES];
    logic [VW-1:0]            r_v;
    logic [1:0]               r_wait;
    logic signed [ACC_W-1:0]  r_acc;

    logic                     w_accept, w_last, w_wait_done;
    logic                     w_hit, w_free;
    logic [VW-1:0]            w_hit_idx, w_free_idx;
    logic [PHASE_WDTH-1:0]    w_phase_new;
    logic signed [DATA_WDTH-1:0] w_mix;

    assign o_dbg_state   = r_state;
    assign o_active_mask = r_active;
    assign w_last        = (r_v == VW'(VOICES - 1));
    assign w_wait_done   = (r_wait == LAT_M1);
    assign w_phase_new   = r_phase[r_v] + i_note_step;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_sample_tick) w_next = S_NOTE;
            S_NOTE:  if (r_active[r_v]) w_next = S_WSTEP;
                     else if (w_last)   w_next = S_DONE;
            S_WSTEP: if (w_wait_done)   w_next = S_PHASE;
            S_PHASE: w_next = S_WSINE;
            S_WSINE: if (w_wait_done)   w_next = S_ACC;
            S_ACC:   w_next = w_last ? S_DONE : S_NOTE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_note_ready = (r_state == S_IDLE);
        w_accept     = i_note_valid && (r_state == S_IDLE);
    end

    // Slot lookup. The loop runs downward, so the lowest free index wins. At
    // most one active slot can hold a given note, because a repeated note-on
    // retriggers the existing slot.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (r_active[i] && (r_note[i] == i_note_num)) begin
                w_hit     = 1'b1;
                w_hit_idx = VW'(i);
            end
            if (!r_active[i]) begin
                w_free     = 1'b1;
                w_free_idx = VW'(i);
            end
        end
    end

    // Slot state. Note events are only accepted in IDLE, so they never
    // collide with the PHASE update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_note[i]  <= '0;
                r_phase[i] <= '0;
            end
        end else if (w_accept) begin
            if (i_note_on) begin
                if (w_hit) begin
                    r_phase[w_hit_idx] <= '0;
                end else if (w_free) begin
                    r_active[w_free_idx] <= 1'b1;
                    r_note[w_free_idx]   <= i_note_num;
                    r_phase[w_free_idx]  <= '0;
                end
            end else if (w_hit) begin
                r_active[w_hit_idx] <= 1'b0;
            end
        end else if (r_state == S_PHASE) begin
            r_phase[r_v] <= w_phase_new;
        end
    end

`ifdef DDS_SCHED_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(VW + 1){1'b0}}, {(DATA_WDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(VW + 1){1'b1}}, {(DATA_WDTH - 1){1'b0}}};
    always_comb begin
        if (r_acc > ACC_MAX)      w_mix = ACC_MAX[DATA_WDTH-1:0];
        else if (r_acc < ACC_MIN) w_mix = ACC_MIN[DATA_WDTH-1:0];
        else                      w_mix = r_acc[DATA_WDTH-1:0];
    end
`else
    // An arithmetic shift by log2(VOICES), then truncation to DATA_WDTH, is
    // the same as taking the upper DATA_WDTH bits of the accumulator.
    assign w_mix = r_acc[ACC_W-1:VW];
`endif

    // Sequencing datapath and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v         <= '0;
            r_wait      <= '0;
            r_acc       <= '0;
            o_note_addr <= '0;
            o_phase_out <= '0;
            o_mix_out   <= '0;
            o_mix_valid <= 1'b0;
            o_note_drop <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_mix_valid <= (r_state == S_DONE);
            o_note_drop <= w_accept && i_note_on && !w_hit && !w_free;
            if (i_sample_tick && (r_state != S_IDLE)) o_overrun <= 1'b1;
            case (r_state)
                S_IDLE: if (i_sample_tick) begin
                    r_v   <= '0;
                    r_acc <= '0;
                end
                S_NOTE: if (r_active[r_v]) begin
                    o_note_addr <= r_note[r_v];
                    r_wait      <= '0;
                end else begin
                    r_v <= r_v + VW'(1);
                end
                S_WSTEP, S_WSINE: r_wait <= w_wait_done ? 2'd0 : r_wait + 2'd1;
                S_PHASE: begin
                    o_phase_out <= w_phase_new;
                    r_wait      <= '0;
                end
                S_ACC: begin
                    r_acc <= r_acc + {{VW{i_sine_value[DATA_WDTH-1]}}, i_sine_value};
                    r_v   <= r_v + VW'(1);
                end
                S_DONE: o_mix_out <= w_mix;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_voice_scheduler.sv
module tb_dds_voice_scheduler;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sample_tick, note_valid, note_ready, note_on, note_drop;
    logic [6:0]  note_num, note_addr;
    logic [15:0] note_step, phase_out;
    logic [23:0] sine_value, mix_out;
    logic        mix_valid, overrun;
    logic [3:0]  active_mask;
    logic [2:0]  dbg_state;

    dds_voice_scheduler #(
        .VOICES(4), .DATA_WDTH(24), .PHASE_WDTH(16), .NOTE_WDTH(7), .LUT_LAT(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_tick(sample_tick),
        .i_note_valid(note_valid), .o_note_ready(note_ready), .i_note_on(note_on),
        .i_note_num(note_num), .o_note_drop(note_drop), .o_note_addr(note_addr),
        .i_note_step(note_step), .o_phase_out(phase_out), .i_sine_value(sine_value),
        .o_mix_out(mix_out), .o_mix_valid(mix_valid), .o_active_mask(active_mask),
        .o_overrun(overrun), .o_dbg_state(dbg_state)
    );

    // ---------------- ROM models (latency 1) ----------------
    // The step ROM holds a nonzero step only for note 60.
    logic [15:0] rom_step   = 16'h0100;
    logic        sine_const = 1'b0;
    always @(posedge clk) begin
        note_step  <= (note_addr == 7'd60) ? rom_step : 16'h0000;
        sine_value <= sine_const ? 24'h400000 : {8'h00, phase_out};
    end

    // ---------------- scoreboard ----------------
    // entry = {check_phase, latency[7:0], phase[15:0], mix[23:0]}
    logic [48:0] exp_q[$];
    logic [48:0] mon_e;
    int vectors = 0, miscompares = 0, tick_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] mix_model(input longint s);
        longint t;
`ifdef DDS_SCHED_SAT_EN
        if (s > 64'sd8388607)  t = 64'sd8388607;
        else if (s < -64'sd8388608) t = -64'sd8388608;
        else t = s;
`else
        t = s >>> 2;
`endif
        return t[23:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && mix_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_mix_valid: got mix_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("mix_out", {8'h0, mix_out}, {8'h0, mon_e[23:0]});
                check("mix_latency", cyc - tick_n, {24'h0, mon_e[47:40]});
                if (mon_e[48]) check("phase_out", {16'h0, phase_out}, {16'h0, mon_e[39:24]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_tick(input logic push, input logic [23:0] mix,
                              input logic [15:0] ph, input logic chk_ph, input int lat);
        @(negedge clk);
        sample_tick = 1'b1;
        if (push) begin
            tick_n = cyc;
            exp_q.push_back({chk_ph, 8'(lat), ph, mix});
        end
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic wait_mix();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL mix_timeout: got no mix_valid in 200 cycles (state %0d), required one", dbg_state);
            exp_q.delete();
        end
    endtask

    task automatic note_evt(input logic on, input logic [6:0] num,
                            input logic exp_drop, input logic [3:0] exp_mask);
        @(negedge clk);
        check("note_ready", {31'h0, note_ready}, 32'h1);
        note_valid = 1'b1;
        note_on    = on;
        note_num   = num;
        @(negedge clk);
        note_valid = 1'b0;
        check("note_drop", {31'h0, note_drop}, {31'h0, exp_drop});
        check("active_mask", {28'h0, active_mask}, {28'h0, exp_mask});
    endtask

    task automatic check_reset_outputs();
        check("rst_note_ready", {31'h0, note_ready}, 32'h1);
        check("rst_note_drop", {31'h0, note_drop}, 32'h0);
        check("rst_note_addr", {25'h0, note_addr}, 32'h0);
        check("rst_phase_out", {16'h0, phase_out}, 32'h0);
        check("rst_mix_out", {8'h0, mix_out}, 32'h0);
        check("rst_mix_valid", {31'h0, mix_valid}, 32'h0);
        check("rst_active_mask", {28'h0, active_mask}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] ph;
        rst_n = 1'b0; sample_tick = 1'b0; note_valid = 1'b0; note_on = 1'b0; note_num = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();

        // empty tick: every slot is inactive, so 4 + 2 = 6 cycles
        pulse_tick(1'b1, mix_model(0), 16'h0, 1'b0, 6);
        wait_mix();
        check("overrun_clear", {31'h0, overrun}, 32'h0);

        // one voice: 5 + 3 + 2 = 10 cycles, sine = phase
        note_evt(1'b1, 7'd60, 1'b0, 4'b0001);
        for (int k = 1; k <= 3; k++) begin
            ph = 16'(k * 256);
            pulse_tick(1'b1, mix_model(longint'(ph)), ph, 1'b1, 10);
            wait_mix();
        end
        rom_step = 16'hFC00;
        pulse_tick(1'b1, mix_model(longint'(16'hFF00)), 16'hFF00, 1'b1, 10);
        wait_mix();
        rom_step = 16'h0100;
        pulse_tick(1'b1, mix_model(0), 16'h0000, 1'b1, 10);
        wait_mix();

        // retrigger resets the phase without using a new slot; an unknown note-off is ignored
        note_evt(1'b1, 7'd60, 1'b0, 4'b0001);
        pulse_tick(1'b1, mix_model(longint'(16'h0100)), 16'h0100, 1'b1, 10);
        wait_mix();
        note_evt(1'b0, 7'd99, 1'b0, 4'b0001);

        // fill the slots, drop the fifth note, free slot 2 and reuse it
        note_evt(1'b1, 7'd61, 1'b0, 4'b0011);
        note_evt(1'b1, 7'd62, 1'b0, 4'b0111);
        note_evt(1'b1, 7'd63, 1'b0, 4'b1111);
        note_evt(1'b1, 7'd64, 1'b1, 4'b1111);
        note_evt(1'b0, 7'd62, 1'b0, 4'b1011);
        sine_const = 1'b1;
        pulse_tick(1'b1, mix_model(3 * 64'sd4194304), 16'h0, 1'b0, 18);
        wait_mix();
        note_evt(1'b1, 7'd70, 1'b0, 4'b1111);
        pulse_tick(1'b1, mix_model(4 * 64'sd4194304), 16'h0, 1'b0, 22);
        wait_mix();

        // second tick five cycles into a sample: discarded, overrun sticks
        pulse_tick(1'b1, mix_model(4 * 64'sd4194304), 16'h0, 1'b0, 22);
        repeat (4) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        wait_mix();
        repeat (30) @(negedge clk);
        check("overrun_set", {31'h0, overrun}, 32'h1);
        pulse_tick(1'b1, mix_model(4 * 64'sd4194304), 16'h0, 1'b0, 22);
        wait_mix();
        check("overrun_sticky", {31'h0, overrun}, 32'h1);

        // reset while in WSINE of slot 0 (tick cycle + NOTE, WSTEP, PHASE)
        pulse_tick(1'b0, 24'h0, 16'h0, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_mask", {28'h0, active_mask}, 32'h0);
        pulse_tick(1'b1, mix_model(0), 16'h0, 1'b0, 6);
        wait_mix();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
